// File: rtl/tm_pkg.sv
// Shared definitions for the Tsetlin Machine class-sum reducer.
//   tm_state_e     : reducer FSM states
//   clause_chunks(): number of CHUNK_W-wide chunks needed to carry one class's clauses
//   last_bits()    : number of live clause bits in the final chunk of a class
//   EVEN_MASK_MAX  : bit i set when i is even; sliced to CHUNK_W by users
package tm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ARGMAX = 2'd2,
    DONE   = 2'd3
  } tm_state_e;

  // Widest chunk the polarity constant covers.
  localparam int MAX_CHUNK_W = 256;

  // Even clause positions vote +1.
  localparam logic [MAX_CHUNK_W-1:0] EVEN_MASK_MAX = {(MAX_CHUNK_W/2){2'b01}};

  function automatic int clause_chunks(input int clauses, input int chunk_w);
    return (clauses + chunk_w - 1) / chunk_w;
  endfunction

  // A zero remainder means the final chunk is fully populated.
  function automatic int last_bits(input int clauses, input int chunk_w);
    return ((clauses % chunk_w) == 0) ? chunk_w : (clauses % chunk_w);
  endfunction

endpackage

// File: rtl/tm_chunk_popcount.sv
// Combinational signed vote of one clause chunk.
//   chunk      : raw clause outputs
//   valid_mask : clause bits that exist (final chunk of a class is partial)
//   pos_mask   : bits that vote +1; the remaining valid bits vote -1
//   delta      : popcount(+1 bits) - popcount(-1 bits), two's complement
module tm_chunk_popcount #(
  parameter int CHUNK_W = 32
) (
  input  logic [CHUNK_W-1:0]             chunk,
  input  logic [CHUNK_W-1:0]             valid_mask,
  input  logic [CHUNK_W-1:0]             pos_mask,
  output logic signed [$clog2(CHUNK_W):0] delta
);

  localparam int PW = $clog2(CHUNK_W) + 1;

  logic [CHUNK_W-1:0] live;
  logic [PW-1:0]      pos_cnt;
  logic [PW-1:0]      neg_cnt;

  assign live = chunk & valid_mask;

  always_comb begin
    pos_cnt = '0;
    neg_cnt = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      pos_cnt = pos_cnt + PW'(live[i] & pos_mask[i]);
      neg_cnt = neg_cnt + PW'(live[i] & ~pos_mask[i]);
    end
  end

  // At most half the bits land on each side, so the difference fits PW bits.
  assign delta = $signed(pos_cnt - neg_cnt);

endmodule

// File: rtl/tm_class_sum_reducer.sv
// Class-sum stage of the Tsetlin Machine classifier.
// Consumes clause chunks class-major / chunk-minor, accumulates one signed
// vote per class, runs a sequential argmax, and offers the result over a
// valid/ready handshake.
//   clk, rst_flag (async, active high), stop_flag (sync abort to IDLE)
//   in_valid/in_ready/in_chunk    : chunk input, accepted when both high;
//                                   in_ready is forced low while stop_flag=1
//   out_valid/out_ready           : result handshake; out_valid holds until accepted
//   class_sums                    : class c at [c*SUM_W +: SUM_W], signed
//   pred_class                    : argmax index, ties to the lowest index
//   full_done                     : one-cycle pulse after the result is accepted
// Build option: define TM_SUM_CLAMP_EN to saturate every written sum to
// [-THRESHOLD, +THRESHOLD]; otherwise sums are exact and THRESHOLD is unused.
module tm_class_sum_reducer
  import tm_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int CLAUSES     = 2000,
  parameter int CHUNK_W     = 32,
  parameter int SUM_W       = 32,
  parameter int THRESHOLD   = 100
) (
  input  logic                           clk,
  input  logic                           rst_flag,
  input  logic                           stop_flag,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHUNK_W-1:0]             in_chunk,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_CLASSES*SUM_W-1:0]   class_sums,
  output logic [$clog2(NUM_CLASSES)-1:0] pred_class,
  output logic                           full_done
);

  localparam int CC    = clause_chunks(CLAUSES, CHUNK_W);
  localparam int CHK_W = (CC > 1) ? $clog2(CC) : 1;
  localparam int CLS_W = $clog2(NUM_CLASSES);
  localparam int ARG_W = $clog2(NUM_CLASSES + 1);
  localparam int PW    = $clog2(CHUNK_W) + 1;

  localparam logic [CHUNK_W-1:0] LAST_MASK  =
    {CHUNK_W{1'b1}} >> (CHUNK_W - last_bits(CLAUSES, CHUNK_W));
  localparam logic [CHUNK_W-1:0] EVEN_MASK  = EVEN_MASK_MAX[CHUNK_W-1:0];
  localparam logic [CHK_W-1:0]   LAST_CHUNK = CHK_W'(CC - 1);
  localparam logic [CLS_W-1:0]   LAST_CLASS = CLS_W'(NUM_CLASSES - 1);
  localparam logic [ARG_W-1:0]   ARG_END    = ARG_W'(NUM_CLASSES);

  if (SUM_W < $clog2(CLAUSES) + 1) begin : g_sum_w_chk
    $error("SUM_W too narrow for CLAUSES");
  end
  if (SUM_W <= PW) begin : g_sum_pw_chk
    $error("SUM_W must exceed the chunk delta width");
  end
  if (NUM_CLASSES < 2) begin : g_cls_chk
    $error("NUM_CLASSES must be at least 2");
  end
  if (CHUNK_W < 2 || CHUNK_W > MAX_CHUNK_W) begin : g_chunk_chk
    $error("CHUNK_W out of range");
  end
  if (THRESHOLD < 0) begin : g_thr_chk
    $error("THRESHOLD must be non-negative");
  end

  tm_state_e                 state;
  logic [CHK_W-1:0]          chunk_cnt;
  logic [CLS_W-1:0]          class_cnt;
  logic [ARG_W-1:0]          arg_cnt;
  logic signed [SUM_W-1:0]   sums [NUM_CLASSES];
  logic signed [SUM_W-1:0]   best_val;
  logic [CLS_W-1:0]          best_idx;

  logic                      accept;
  logic                      last_chunk;
  logic                      last_class;
  logic [CHUNK_W-1:0]        valid_mask;
  logic [CHUNK_W-1:0]        pos_mask;
  logic signed [PW-1:0]      delta;
  logic signed [SUM_W-1:0]   base_sum;
  logic signed [SUM_W-1:0]   raw_sum;
  logic signed [SUM_W-1:0]   new_sum;
  logic signed [SUM_W-1:0]   arg_val;

  assign in_ready   = !stop_flag && (state == IDLE || state == ACCUM);
  assign accept     = in_valid && in_ready;
  assign last_chunk = (chunk_cnt == LAST_CHUNK);
  assign last_class = (class_cnt == LAST_CLASS);
  assign valid_mask = last_chunk ? LAST_MASK : {CHUNK_W{1'b1}};
  // With an odd chunk width the global parity of bit 0 flips every chunk.
  assign pos_mask   = ((CHUNK_W % 2) == 1 && chunk_cnt[0]) ? ~EVEN_MASK : EVEN_MASK;

  tm_chunk_popcount #(.CHUNK_W(CHUNK_W)) u_popcount (
    .chunk      (in_chunk),
    .valid_mask (valid_mask),
    .pos_mask   (pos_mask),
    .delta      (delta)
  );

  // The first accept of a frame starts from zero rather than the held result.
  assign base_sum = (state == IDLE) ? '0 : sums[class_cnt];
  assign raw_sum  = base_sum + {{(SUM_W-PW){delta[PW-1]}}, delta};
  assign arg_val  = sums[arg_cnt[CLS_W-1:0]];

`ifdef TM_SUM_CLAMP_EN
  localparam logic signed [SUM_W-1:0] T_POS = SUM_W'(THRESHOLD);
  localparam logic signed [SUM_W-1:0] T_NEG = -T_POS;

  always_comb begin
    new_sum = raw_sum;
    if (raw_sum > T_POS) new_sum = T_POS;
    else if (raw_sum < T_NEG) new_sum = T_NEG;
  end
`else
  assign new_sum = raw_sum;
`endif

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_pack
    assign class_sums[c*SUM_W +: SUM_W] = sums[c];
  end

  always_ff @(posedge clk or posedge rst_flag) begin
    if (rst_flag) begin
      state      <= IDLE;
      chunk_cnt  <= '0;
      class_cnt  <= '0;
      arg_cnt    <= '0;
      best_val   <= '0;
      best_idx   <= '0;
      pred_class <= '0;
      out_valid  <= 1'b0;
      full_done  <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) sums[c] <= '0;
    end else begin
      full_done <= 1'b0;
      if (stop_flag) begin
        state     <= IDLE;
        chunk_cnt <= '0;
        class_cnt <= '0;
        arg_cnt   <= '0;
        out_valid <= 1'b0;
        for (int c = 0; c < NUM_CLASSES; c++) sums[c] <= '0;
      end else begin
        case (state)
          IDLE, ACCUM: begin
            if (accept) begin
              if (state == IDLE) begin
                for (int c = 0; c < NUM_CLASSES; c++) sums[c] <= '0;
              end
              // Later assignment wins over the clear above for this class.
              sums[class_cnt] <= new_sum;
              if (last_chunk) begin
                chunk_cnt <= '0;
                if (last_class) begin
                  class_cnt <= '0;
                  arg_cnt   <= '0;
                  state     <= ARGMAX;
                end else begin
                  class_cnt <= class_cnt + CLS_W'(1);
                  state     <= ACCUM;
                end
              end else begin
                chunk_cnt <= chunk_cnt + CHK_W'(1);
                state     <= ACCUM;
              end
            end
          end
          ARGMAX: begin
            if (arg_cnt == ARG_END) begin
              pred_class <= best_idx;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              // Class 0 seeds the search; strict > keeps the lowest index on ties.
              if (arg_cnt == '0 || arg_val > best_val) begin
                best_val <= arg_val;
                best_idx <= arg_cnt[CLS_W-1:0];
              end
              arg_cnt <= arg_cnt + ARG_W'(1);
            end
          end
          DONE: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              full_done <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
